multicycle_controller: RTL

Multicycle successor to the single-cycle main decoder. A registered FSM sequences each instruction over 3–5 cycles and drives the shared-ALU/shared-memory datapath strobes. It adds memory wait handshaking, an optional stall timeout, illegal-opcode flagging, and jal/lui support. It sits in the control unit beside the existing ALU decoder, which consumes ALUOp unchanged.

---
 rtl/multicycle_controller_pkg.sv | 40 ++++
 rtl/multicycle_controller_if.sv | 22 ++
 rtl/multicycle_controller_imm_src_decoder.sv | 13 +
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// ctrl_pkg: states, opcodes and datapath select encodings shared by the multicycle control unit
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, LUI, ILLEGAL
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  function automatic state_t decode_state(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_STORE) ? MEMADR :
           op == OP_R      ? EXECR  :
           op == OP_IMM    ? EXECI  :
           op == OP_BRANCH ? BRANCH :
           op == OP_JAL    ? JAL    :
           op == OP_LUI    ? LUI    : ILLEGAL;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath strobes; master is the controller side
interface multicycle_controller_if #(parameter int INSTRET_W = 32);
  logic [6:0] op;
  logic mem_ready;
  logic PCWrite, AdrSrc, MemWrite, IRWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic RegWrite, Branch;
  logic [1:0] ALUOp;
  logic illegal, mem_err;
  logic [INSTRET_W-1:0] instret;
  modport master (
    input op, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
           RegWrite, Branch, ALUOp, illegal, mem_err, instret
  );
  modport slave (
    output op, mem_ready,
    input PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
          RegWrite, Branch, ALUOp, illegal, mem_err, instret
  );
endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// imm_src_decoder: opcode -> immediate format select, shared with later control units
module imm_src_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);
  always_comb
    imm_src = op == OP_STORE  ? IMM_S :
              op == OP_BRANCH ? IMM_B :
              op == OP_JAL    ? IMM_J :
              op == OP_LUI    ? IMM_U : IMM_I;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing shared-ALU/memory datapath with memory wait and timeout.
// CTRL_INSTRET_EN enables the retired-instruction counter; otherwise instret is tied to 0.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int INSTRET_W = 32
) (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
);
  localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [2:0] imm_src;
  logic stall, abort;
  imm_src_decoder u_imm (.op(bus.op), .imm_src(imm_src));
  always_comb begin
    stall = state_q inside {FETCH, MEMREAD, MEMWRITE} && !bus.mem_ready;
    abort = MEM_TIMEOUT > 0 && stall && wait_q == WW'(MEM_TIMEOUT - 1);
    wait_d = stall && !abort ? wait_q + 1'b1 : '0;
    bus.PCWrite = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA = SRCA_PC;
    bus.ALUSrcB = SRCB_RS2;
    bus.ImmSrc = imm_src;
    bus.RegWrite = 1'b0;
    bus.Branch = 1'b0;
    bus.ALUOp = ALUOP_ADD;
    bus.illegal = 1'b0;
    bus.mem_err = 1'b0;
    state_d = state_q;
    case (state_q)
      FETCH: begin
        bus.ALUSrcB = SRCB_FOUR;
        bus.ResultSrc = RES_ALURES;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        state_d = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        state_d = decode_state(bus.op);
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        state_d = bus.op == OP_STORE ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemWrite = !abort;
        state_d = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUOp = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUOp = ALUOP_SUB;
        bus.Branch = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
        state_d = ALUWB;
      end
      LUI: begin
        bus.ALUSrcA = SRCA_ZERO;
        bus.ALUSrcB = SRCB_IMM;
        state_d = ALUWB;
      end
      ILLEGAL: begin
        bus.illegal = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (abort) begin
      bus.mem_err = 1'b1;
      state_d = FETCH;
    end
    // reset must never leak a write strobe, whatever state it interrupts
    if (!rst_n) begin
      bus.PCWrite = 1'b0;
      bus.IRWrite = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.Branch = 1'b0;
      bus.illegal = 1'b0;
      bus.mem_err = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
    end
  end
`ifdef CTRL_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q, instret_d;
  always_comb
    instret_d = instret_q + INSTRET_W'(state_q inside {MEMWB, ALUWB, BRANCH} ||
                                       (state_q == MEMWRITE && bus.mem_ready));
  always_ff @(posedge clk) instret_q <= !rst_n ? '0 : instret_d;
  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif
endmodule
